// File: rtl/swap_sequencer.sv
//==============================================================================
// Module      : swap_sequencer
// Description : Reverses the address range [lo_addr, hi_addr] in a swapper's
//               register file by issuing paced (lo,hi), (lo+1,hi-1), ... swaps.
//               Optional abort input is enabled by defining SWAP_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module swap_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int SWAP_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [ADDR_W-1:0] hi_addr,
`ifdef SWAP_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              swap,
    output logic [ADDR_W-1:0] address_A,
    output logic [ADDR_W-1:0] address_B,
    output logic [ADDR_W-1:0] swap_count
);

    localparam int                WCNT_W    = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(SWAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [WCNT_W-1:0] wcnt;

    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] base_count;
    logic              stop_now;
    logic              enter_issue;
    logic              issue_now;

`ifdef SWAP_SEQ_ABORT_EN
    logic abort_pend;
    assign stop_now = ((state == WAIT) || (state == ISSUE)) && (abort || abort_pend);
`else
    assign stop_now = 1'b0;
`endif

    // The swap decision is taken on the edge that enters ISSUE so that swap and
    // the address pair are registered and visible during the ISSUE cycle itself.
    always_comb begin
        src_a       = (state == IDLE) ? lo_addr : a;
        src_b       = (state == IDLE) ? hi_addr : b;
        base_count  = (state == IDLE) ? '0 : swap_count;
        enter_issue = 1'b0;
        case (state)
            IDLE:    enter_issue = start;
            ISSUE:   enter_issue = (SWAP_CYCLES == 1) && swap && !stop_now;
            WAIT:    enter_issue = (wcnt == WCNT_W'(1));
            default: enter_issue = 1'b0;
        endcase
        issue_now = (src_a < src_b) && !stop_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            wcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            swap       <= 1'b0;
            address_A  <= '0;
            address_B  <= '0;
            swap_count <= '0;
`ifdef SWAP_SEQ_ABORT_EN
            abort_pend <= 1'b0;
`endif
        end else begin
            swap <= 1'b0;
            done <= 1'b0;
`ifdef SWAP_SEQ_ABORT_EN
            if (state == DONE) begin
                abort_pend <= 1'b0;
            end else if (stop_now) begin
                abort_pend <= 1'b1;
            end
`endif
            if (enter_issue) begin
                state      <= ISSUE;
                busy       <= 1'b1;
                a          <= src_a;
                b          <= src_b;
                swap_count <= base_count;
                if (issue_now) begin
                    swap       <= 1'b1;
                    address_A  <= src_a;
                    address_B  <= src_b;
                    a          <= src_a + ADDR_W'(1);
                    b          <= src_b - ADDR_W'(1);
                    swap_count <= (base_count == COUNT_MAX) ? base_count
                                                            : base_count + ADDR_W'(1);
                end
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    ISSUE: begin
                        // A pulse already on the wire in this cycle cannot be
                        // withdrawn; an abort here only stops further swaps.
                        if (swap && !stop_now) begin
                            state <= WAIT;
                            wcnt  <= WCNT_LOAD;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    WAIT:    wcnt  <= wcnt - WCNT_W'(1);
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
